sfft_stream_decoder: RTL and testbench
======================================

SFFT_STREAM_DECODER -- requirements
Module: sfft_stream_decoder

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: precision; accumulation window W = 2^BITWIDTH bitstream cycles.
REQ-002 SHALL have parameter NUMINPUTS, default 8: number of complex bitstream lanes (power of two, >=2).
REQ-003 SHALL have derived widths OUTW = BITWIDTH+2 and IDXW = $clog2(2*NUMINPUTS).
REQ-004 SHALL use one clock; reset is asynchronous and active-low, ports iClk and iRstN.
REQ-005 SHALL have port iClk  input  1: clock, all state on rising edge.
REQ-006 SHALL have port iRstN  input  1: asynchronous active-low reset.
REQ-007 SHALL have port iEn  input  1: bitstream-valid qualifier; sampling and window count advance only when high.
REQ-008 SHALL have port iClr  input  1: synchronous clear.
REQ-009 SHALL have port iStart  input  1: starts an accumulation window.
REQ-010 SHALL have port iReal  input  NUMINPUTS: real bitstream bit per lane (SFFT output side).
REQ-011 SHALL have port iImg  input  NUMINPUTS: imaginary bitstream bit per lane.
REQ-012 SHALL have port iReady  input  1: downstream accepts oData.
REQ-013 SHALL have port oValid  output  1: oData/oIdx/oLast valid.
REQ-014 SHALL have port oData  output  OUTW: decoded binary value.
REQ-015 SHALL have port oIdx  output  IDXW: word index; 0..N-1 real lanes, N..2N-1 imaginary lanes.
REQ-016 SHALL have port oLast  output  1: high with final word of a frame.
REQ-017 SHALL have port oBusy  output  1: high in ACCUM or DRAIN.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-019 IDLE->ACCUM on iStart; clears all 2*NUMINPUTS ones-counters (BITWIDTH+1 bits each) and window counter the same cycle.
REQ-020 In ACCUM, each cycle with iEn=1: every lane counter increments by its input bit; window counter increments; iEn=0 freezes all counters.
REQ-021 After the W-th qualified cycle, counts SHALL be snapshotted to a 2*NUMINPUTS-entry buffer and FSM enters DRAIN next cycle.
REQ-022 In DRAIN, oValid=1; words emitted in order idx 0..2N-1; a word transfers on oValid&iReady; oData/oIdx/oLast SHALL stay stable while iReady=0.
REQ-023 oLast=1 only at idx 2N-1; its transfer returns FSM to IDLE, oValid low next cycle.
REQ-024 iStart outside IDLE SHALL be ignored.
REQ-025 Counter range 0..W inclusive; no saturation or wrap may occur.
REQ-026 iClr SHALL force IDLE, zero counters/index, deassert oValid next cycle; iClr with iStart same cycle: iClr wins.
REQ-027 Throughput: one word per cycle with iReady held high; first oValid exactly 1 cycle after last qualified ACCUM cycle.

Reset
REQ-028 iRstN low SHALL immediately force IDLE, all counters, buffer and index to 0, oValid=0, oData=0, oIdx=0, oLast=0, oBusy=0.
REQ-029 Reset mid-ACCUM or mid-DRAIN SHALL discard the frame; no partial frame emitted after release.
REQ-030 First iStart SHALL be honoured on the first rising edge after iRstN deasserts.

Configuration
REQ-031 Macro SFFT_DECODE_BIPOLAR_EN defined: oData = signed two's-complement 2*count - W (range -W..+W).
REQ-032 Macro SFFT_DECODE_BIPOLAR_EN undefined: oData = unsigned count zero-extended to OUTW (range 0..W).

Verification
REQ-033 BITWIDTH=8, N=8, all iReal=1, iImg=0 for 256 cycles, iReady=1 -> bipolar: idx0-7 oData=+256, idx8-15 oData=-256; unipolar: 256 / 0; oLast at idx15.
REQ-034 Alternating 1/0 on every lane for 256 cycles -> bipolar oData=0, unipolar oData=128 for all 16 words.
REQ-035 iEn low for 100 cycles inserted mid-window -> results identical to REQ-034 run; first oValid 357 cycles after iStart.
REQ-036 iReady toggled 1/0 during DRAIN -> each word held stable while iReady=0, 16 transfers total, no duplicates or skips.
REQ-037 iRstN pulsed low at ACCUM cycle 50, then iStart with all-ones -> only one frame, all real words +256; iClr asserted with iStart -> FSM stays IDLE, oBusy=0.

Source files
------------

// File: rtl/sfft_stream_decoder.sv
// Stochastic-bitstream to binary decoder: counts ones per real/imag lane over a 2^BITWIDTH window, then drains the counts as words.
// Define SFFT_DECODE_BIPOLAR_EN for two's-complement output (2*count - W); otherwise the raw count is emitted.
module sfft_stream_decoder #(
  parameter  int BITWIDTH  = 8,
  parameter  int NUMINPUTS = 8,
  localparam int OUTW      = BITWIDTH + 2,
  localparam int IDXW      = $clog2(2 * NUMINPUTS)
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iStart,
  input  logic [NUMINPUTS-1:0] iReal,
  input  logic [NUMINPUTS-1:0] iImg,
  input  logic                 iReady,
  output logic                 oValid,
  output logic [OUTW-1:0]      oData,
  output logic [IDXW-1:0]      oIdx,
  output logic                 oLast,
  output logic                 oBusy
);

  localparam int LANES = 2 * NUMINPUTS;
  localparam int CNTW  = BITWIDTH + 1;
  localparam logic [CNTW-1:0] WIN      = CNTW'(2 ** BITWIDTH);
  localparam logic [CNTW-1:0] LAST_WIN = WIN - CNTW'(1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LANES-1:0]   bits;
  logic [CNTW-1:0]    cnt  [LANES];
  logic [CNTW-1:0]    snap [LANES];
  logic [CNTW-1:0]    win;
  logic [IDXW-1:0]    idx;
  logic               start_ok;
  logic               sample;
  logic               win_done;
  logic               xfer;
  logic               last_xfer;

  // Converts a ones-count into the output number format.
  function automatic logic [OUTW-1:0] decode(input logic [CNTW-1:0] count);
    logic signed [OUTW-1:0] val;
`ifdef SFFT_DECODE_BIPOLAR_EN
    val = signed'({count, 1'b0}) - signed'(OUTW'(WIN));
`else
    val = signed'({1'b0, count});
`endif
    return val;
  endfunction

  // Lanes 0..N-1 carry the real bitstreams, N..2N-1 the imaginary ones.
  assign bits      = {iImg, iReal};
  assign start_ok  = (state == IDLE) && iStart;
  assign sample    = (state == ACCUM) && iEn;
  assign win_done  = sample && (win == LAST_WIN);
  assign xfer      = (state == DRAIN) && iReady;
  assign last_xfer = xfer && (idx == LAST_IDX);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (iClr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (iStart)    state_nxt = ACCUM;
        ACCUM:   if (win_done)  state_nxt = DRAIN;
        DRAIN:   if (last_xfer) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // Accumulation stage: per-lane ones counters and the qualified-cycle counter.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
      win <= '0;
    end else if (iClr || start_ok) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
      win <= '0;
    end else if (sample) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= cnt[i] + CNTW'(bits[i]);
      win <= win + CNTW'(1);
    end
  end

  // Snapshot stage: the final sample is folded in directly so DRAIN can start on the next cycle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < LANES; i++) snap[i] <= '0;
    end else if (iClr) begin
      for (int i = 0; i < LANES; i++) snap[i] <= '0;
    end else if (win_done) begin
      for (int i = 0; i < LANES; i++) snap[i] <= cnt[i] + CNTW'(bits[i]);
    end
  end

  // Drain stage: word index advances only on an accepted transfer.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      idx <= '0;
    end else if (iClr || last_xfer) begin
      idx <= '0;
    end else if (xfer) begin
      idx <= idx + IDXW'(1);
    end
  end

  always_comb begin
    oValid = (state == DRAIN);
    oBusy  = (state != IDLE);
    oIdx   = idx;
    oLast  = oValid && (idx == LAST_IDX);
    oData  = oValid ? decode(snap[idx]) : '0;
  end

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Scoreboard bench for sfft_stream_decoder: a lane-count model pushes expected words, a monitor pops them on each transfer.
module tb_sfft_stream_decoder;

  localparam int BW   = 8;
  localparam int N    = 8;
  localparam int L    = 2 * N;
  localparam int W    = 1 << BW;
  localparam int OUTW = BW + 2;
  localparam int IDXW = $clog2(L);

  logic            iClk;
  logic            iRstN;
  logic            iEn;
  logic            iClr;
  logic            iStart;
  logic [N-1:0]    iReal;
  logic [N-1:0]    iImg;
  logic            iReady;
  logic            oValid;
  logic [OUTW-1:0] oData;
  logic [IDXW-1:0] oIdx;
  logic            oLast;
  logic            oBusy;

  sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(N)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart),
    .iReal(iReal), .iImg(iImg), .iReady(iReady),
    .oValid(oValid), .oData(oData), .oIdx(oIdx), .oLast(oLast), .oBusy(oBusy)
  );

  typedef struct {
    int              idx;
    logic [OUTW-1:0] data;
    logic            last;
  } word_t;

  word_t sbq[$];
  int    model[L];
  int    total = 0;
  int    bad   = 0;
  int    xfers = 0;
  int    cyc   = 0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OUTW-1:0] expect_data(input int c);
`ifdef SFFT_DECODE_BIPOLAR_EN
    return OUTW'(2 * c - W);
`else
    return OUTW'(c);
`endif
  endfunction

  // Monitor: samples 2 time units after the falling edge, when inputs and outputs are settled.
  initial begin
    logic            held;
    logic [OUTW-1:0] hd;
    logic [IDXW-1:0] hi;
    logic            hl;
    word_t           w;
    held = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    forever begin
      @(negedge iClk);
      #2;
      if (held && oValid) begin
        check("hold_data", oData, hd);
        check("hold_idx", oIdx, hi);
        check("hold_last", oLast, hl);
      end
      held = oValid && !iReady;
      hd = oData; hi = oIdx; hl = oLast;
      if (oValid && iReady) begin
        xfers++;
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          w = sbq.pop_front();
          check("word_idx", oIdx, w.idx);
          check("word_data", oData, w.data);
          check("word_last", oLast, w.last);
        end
      end
    end
  end

  task automatic gen(input int kind, input int k, output logic [N-1:0] re, output logic [N-1:0] im);
    case (kind)
      0:       begin re = '1; im = '0; end
      1:       begin re = (k % 2 == 0) ? '1 : '0; im = re; end
      3:       begin re = '1; im = '1; end
      default: begin re = N'($urandom); im = N'($urandom); end
    endcase
  endtask

  task automatic quiet();
    iEn = 1'b0; iStart = 1'b0; iClr = 1'b0; iReal = '0; iImg = '0;
  endtask

  // Drives a full window (optionally with an iEn gap and a stray iStart) and queues the expected words.
  task automatic accum_window(input int kind, input int gap_at, input int gap_len,
                              input int spulse, input bit pre, output int c0);
    logic [N-1:0] re, im;
    for (int i = 0; i < L; i++) model[i] = 0;
    if (!pre) @(negedge iClk);
    quiet();
    iStart = 1'b1;
    c0 = cyc;
    for (int k = 0; k < W; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge iClk);
          iStart = 1'b0; iEn = 1'b0;
          iReal = N'($urandom); iImg = N'($urandom);
        end
      end
      @(negedge iClk);
      iStart = (k == spulse);
      iEn = 1'b1;
      gen(kind, k, re, im);
      iReal = re; iImg = im;
      for (int i = 0; i < N; i++) begin
        model[i]     += int'(re[i]);
        model[N + i] += int'(im[i]);
      end
      if (k == 10) begin
        #1;
        check("busy_accum", oBusy, 1);
      end
    end
    for (int l = 0; l < L; l++) sbq.push_back('{l, expect_data(model[l]), l == L - 1});
  endtask

  // Runs the drain with a given iReady pattern; returns cycles from iStart to the first oValid.
  task automatic drain(input int mode, input int c0, output int lat);
    int x0, vcyc;
    x0 = xfers;
    vcyc = 0;
    lat = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge iClk);
      quiet();
      iStart = (t == 3);
      case (mode)
        0:       iReady = 1'b1;
        1:       iReady = (t % 2 == 0);
        default: iReady = 1'($urandom);
      endcase
      #2;
      if (oValid && lat < 0) lat = cyc - c0;
      if (oValid) vcyc++;
      if (!oValid && lat >= 0) break;
    end
    check("drain_xfers", xfers - x0, L);
    check("sb_drained", sbq.size(), 0);
    check("busy_after", oBusy, 0);
    if (mode == 0) check("drain_cycles", vcyc, L);
    iReady = 1'b1;
  endtask

  initial begin
    int c0, lat;
    iRstN = 1'b0; iReady = 1'b1;
    quiet();
    #1;
    check("rst_valid", oValid, 0);
    check("rst_data", oData, 0);
    check("rst_idx", oIdx, 0);
    check("rst_last", oLast, 0);
    check("rst_busy", oBusy, 0);
    repeat (3) @(negedge iClk);
    iRstN = 1'b1;

    // All real ones, imag zeros.
    accum_window(0, -1, 0, -1, 1'b0, c0);
    drain(0, c0, lat);
    check("latency_plain", lat, W + 1);

    // Alternating bits on every lane.
    accum_window(1, -1, 0, -1, 1'b0, c0);
    drain(0, c0, lat);
    check("latency_alt", lat, W + 1);

    // Same pattern with a 100-cycle iEn gap and a stray iStart mid-window.
    accum_window(1, 128, 100, 100, 1'b0, c0);
    drain(0, c0, lat);
    check("latency_gap", lat, W + 100 + 1);

    // Random data with iReady toggling, then random backpressure.
    accum_window(2, -1, 0, -1, 1'b0, c0);
    drain(1, c0, lat);
    accum_window(2, 60, 7, -1, 1'b0, c0);
    drain(2, c0, lat);

    // Reset at ACCUM cycle 50 discards the frame; iStart with release is honoured.
    @(negedge iClk);
    quiet();
    iStart = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge iClk);
      iStart = 1'b0; iEn = 1'b1; iReal = '1; iImg = N'($urandom);
    end
    @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("rst_mid_busy", oBusy, 0);
    check("rst_mid_valid", oValid, 0);
    @(negedge iClk);
    iRstN = 1'b1;
    accum_window(0, -1, 0, -1, 1'b1, c0);
    drain(0, c0, lat);
    check("latency_after_rst", lat, W + 1);

    // iClr together with iStart in IDLE.
    @(negedge iClk);
    quiet();
    iClr = 1'b1; iStart = 1'b1;
    @(negedge iClk);
    quiet();
    #1;
    check("clr_start_busy", oBusy, 0);
    @(negedge iClk);
    #1;
    check("clr_start_busy2", oBusy, 0);

    // iClr in the middle of ACCUM.
    @(negedge iClk);
    quiet();
    iStart = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge iClk);
      iStart = 1'b0; iEn = 1'b1; iReal = N'($urandom); iImg = N'($urandom);
    end
    @(negedge iClk);
    quiet();
    iClr = 1'b1;
    @(negedge iClk);
    quiet();
    #1;
    check("clr_accum_busy", oBusy, 0);
    accum_window(3, -1, 0, -1, 1'b0, c0);
    drain(0, c0, lat);

    // iClr in the middle of DRAIN, after a few transfers and a stall.
    accum_window(2, -1, 0, -1, 1'b0, c0);
    for (int t = 0; t < 8; t++) begin
      @(negedge iClk);
      quiet();
      iReady = (t < 5);
    end
    @(negedge iClk);
    quiet();
    iReady = 1'b0; iClr = 1'b1;
    sbq.delete();
    @(negedge iClk);
    quiet();
    iReady = 1'b1;
    #2;
    check("clr_drain_valid", oValid, 0);
    check("clr_drain_idx", oIdx, 0);
    check("clr_drain_busy", oBusy, 0);
    accum_window(2, 200, 3, -1, 1'b0, c0);
    drain(0, c0, lat);
    check("latency_after_clr", lat, W + 3 + 1);

    repeat (3) @(negedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
